// File: rtl/keybd_pkg.sv
// Shared PS/2 keyboard scan-code constants, prefix FSM states and key event type.
// Imported by keybuf_fifo and key_event_fifo.
package keybd_pkg;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_BAT  = 8'hAA;
  localparam logic [7:0] SC_ACK  = 8'hFA;
  localparam logic [7:0] SC_ECHO = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } kb_state_e;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_event_t;

  function automatic logic is_status(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO);
  endfunction

endpackage

// File: rtl/keybuf_fifo.sv
// Synchronous show-ahead FIFO of key events; head value holds when empty.
// Ports: clk_i, rst_ni, push_i/data_i, pop_i, data_o, valid_o, count_o, full_o.
module keybuf_fifo
  import keybd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  key_event_t data_i,
  input  logic       pop_i,
  output key_event_t data_o,
  output logic       valid_o,
  output logic [4:0] count_o,
  output logic       full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  key_event_t     mem_q [DEPTH];
  key_event_t     hold_q;
  logic [AW-1:0]  rptr_q, wptr_q;
  logic [4:0]     count_q;
  logic           do_pop, do_push;

  assign valid_o = (count_q != 5'd0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;

  // a pop on an empty FIFO is ignored; a full FIFO accepts a push only
  // when the head leaves in the same cycle
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign data_o = valid_o ? mem_q[rptr_q] : hold_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      if (valid_o) hold_q <= mem_q[rptr_q];
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push) wptr_q <= wptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/key_event_fifo.sv
// PS/2 scan-code decoder: prefix FSM, typematic repeat filter, event FIFO.
// Ports: clk, rst_n, in_code/in_valid, out_code/out_ext/out_valid/out_ready, count, overflow.
module key_event_fifo
  import keybd_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_code,
  input  logic       in_valid,
  output logic [7:0] out_code,
  output logic       out_ext,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] count,
  output logic       overflow
);

  kb_state_e  state_q, state_d;
  key_event_t held_q;
  logic       held_valid_q;
  logic       overflow_q;

  key_event_t ev;
  key_event_t head;
  logic       make_ev, brk_ev, is_rpt, push, pop, full;

  always_comb begin
    state_d  = state_q;
    make_ev  = 1'b0;
    brk_ev   = 1'b0;
    ev.ext   = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    ev.code  = in_code;
    if (in_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (1'b1)
            (in_code == SC_EXT): state_d = ST_EXT;
            (in_code == SC_BRK): state_d = ST_BRK;
            is_status(in_code):  state_d = ST_IDLE;
            default:             make_ev = 1'b1;
          endcase
        end
        ST_EXT: begin
          unique case (1'b1)
            (in_code == SC_BRK): state_d = ST_EXT_BRK;
            (in_code == SC_EXT): state_d = ST_EXT;
            default: begin
              make_ev = 1'b1;
              state_d = ST_IDLE;
            end
          endcase
        end
        default: begin
          brk_ev  = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign is_rpt = (SUPPRESS_REPEAT != 0) && held_valid_q && (held_q == ev);
  assign push   = make_ev && !is_rpt;
  assign pop    = out_ready && out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      held_q       <= '0;
      held_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) begin
        held_q       <= ev;
        held_valid_q <= 1'b1;
      end else if (brk_ev && held_q == ev) begin
        held_valid_q <= 1'b0;
      end
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  keybuf_fifo #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (ev),
    .pop_i   (out_ready),
    .data_o  (head),
    .valid_o (out_valid),
    .count_o (count),
    .full_o  (full)
  );

  assign out_code = head.code;
  assign out_ext  = head.ext;
  assign overflow = overflow_q;

endmodule
